div_bus_sequencer: RTL and testbench
====================================

Name: div_bus_sequencer

Overview:
- Operand/result sequencer directly upstream and downstream of the 6-bit serial divider; owns the divider's `start` and shared input bus.
- Accepts a dividend/divisor pair from the host over a valid/ready handshake and serialises both onto the divider input bus.
- Captures quotient then remainder from the divider output bus and presents them to the host as one registered result with a valid/ready handshake.
- Short-circuits divide-by-zero without starting the divider.

Parameters:
- WIDTH, 6, operand/bus width; must match the divider bus width.
- DIV_LATENCY, 8, cycles from the `start` cycle (cycle 0) to the cycle in which the quotient is on `div_out_bus`; the remainder follows at DIV_LATENCY+1; minimum 3.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  host operand pair valid
- in_ready  output  1  sequencer can accept an operand pair
- dividend  input  WIDTH  unsigned dividend
- divisor  input  WIDTH  unsigned divisor
- start  output  1  one-cycle divider start pulse
- div_in_bus  output  WIDTH  drives the divider input bus
- div_out_bus  input  WIDTH  divider output bus
- res_valid  output  1  result registers valid
- res_ready  input  1  host accepts the result
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  result came from a zero divisor
- busy  output  1  high in any state other than IDLE

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high; no asynchronous reset anywhere.
- Reset values:
  - `start`, `res_valid`, `div_by_zero` = 0.
  - `div_in_bus`, `quotient`, `remainder` = 0.
  - State = IDLE, so `in_ready` = 1 and `busy` = 0.
- `in_ready` = (state==IDLE); it is a decode of the state register only. `busy` = !in_ready.
- Accept:
  - An operand pair is accepted on a rising edge where `in_valid` && `in_ready`.
  - `dividend` and `divisor` are latched into internal registers A and B at that edge.
  - `in_valid` is ignored outside IDLE.
- States and transitions:
  - IDLE: on accept, go to ZERO if `divisor`==0, otherwise go to START.
  - START: `start`=1 and `div_in_bus`=A for exactly this cycle; this is cycle 0. Next state SEND_B.
  - SEND_B: `div_in_bus`=B (cycle 1). Next state WAIT, and the counter is loaded.
  - WAIT: the counter counts cycles since cycle 0. In cycle DIV_LATENCY, capture `div_out_bus` into `quotient` and go to CAP_R.
  - CAP_R: capture `div_out_bus` into `remainder` (cycle DIV_LATENCY+1). Set `res_valid`=1 and `div_by_zero`=0. Go to DONE.
  - ZERO: `quotient`={WIDTH{1}}, `remainder`=A, `div_by_zero`=1, `res_valid`=1. Go to DONE. `start` is never asserted on this path.
  - DONE: hold all result outputs stable while `res_valid`=1 and `res_ready`=0. On `res_ready`=1, clear `res_valid` and return to IDLE.
- Timing:
  - Accept-to-`start` latency is 1 cycle.
  - Accept-to-`res_valid` latency is DIV_LATENCY+3 cycles for a normal divide and 2 cycles for a zero divisor.
  - A new pair is accepted at the earliest 1 cycle after the result handshake. There is no overlap of operations; the divider is never restarted while running.
- `div_in_bus` is 0 in every state other than START and SEND_B.
- `start` is a registered output, high for exactly one cycle per accepted non-zero operation.
- Counter:
  - Width is ceil(log2(DIV_LATENCY+2)) bits.
  - It never wraps inside WAIT and is cleared on leaving WAIT.
- The quotient and remainder registers change only in WAIT→CAP_R, CAP_R or ZERO. They hold their last value in IDLE.
- Reset mid-operation: `rst` dominates all other inputs in any state.
  - State returns to IDLE and `start` deasserts in the same edge.
  - `res_valid` and all registers clear.
  - A pending result is discarded; the divider is assumed restartable by the next `start`.
- Simultaneous `in_valid` and `res_ready` in DONE: only the result handshake completes; the operand pair is not accepted until IDLE.
- Outputs are insensitive to `div_out_bus` outside the two capture cycles.

Test Plan:
- Reset, then dividend=45, divisor=6 with a behavioural divider model at DIV_LATENCY=8.
  - `start` is high in the cycle after accept.
  - `div_in_bus` shows 45 then 6.
  - `res_valid` rises 11 cycles after accept with quotient=7, remainder=3, div_by_zero=0.
- dividend=37, divisor=0:
  - `start` never pulses.
  - 2 cycles after accept: quotient=63, remainder=37, div_by_zero=1.
- 63/1 with `res_ready` held low 5 cycles:
  - quotient=63 and remainder=0 hold stable and `in_ready` stays 0 throughout.
  - Release `res_ready`: `res_valid` drops next edge and `in_ready`=1.
- Back-to-back 20/7 then 5/9 with `in_valid` held high:
  - The second pair is accepted only after the first result handshake.
  - Results are 2 r6 then 0 r5.
- Assert `rst` for 1 cycle during WAIT of 50/4:
  - All outputs return to reset values the next edge.
  - A following 50/4 completes correctly with 12 r2.
- `in_valid` pulsed during WAIT with other operands: they are ignored, and the in-flight result is unchanged.

Source files
------------

// File: rtl/div_bus_sequencer_if.sv
// Host handshake and divider bus bundle for div_bus_sequencer.
// master: host/divider side driving operands, res_ready and the divider output bus.
// slave:  the sequencer itself.
interface div_bus_sequencer_if #(
  parameter int unsigned WIDTH = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             start;
  logic [WIDTH-1:0] div_in_bus;
  logic [WIDTH-1:0] div_out_bus;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, div_out_bus, res_ready,
    input  in_ready, start, div_in_bus, res_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, div_out_bus, res_ready,
    output in_ready, start, div_in_bus, res_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/div_bus_sequencer.sv
// Operand/result sequencer wrapped around a serial divider. Serialises dividend then
// divisor onto the divider input bus, captures quotient then remainder, and short-circuits
// a zero divisor without starting the divider.
module div_bus_sequencer #(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned DIV_LATENCY = 8
) (
  input  logic                clk,
  input  logic                rst,
  div_bus_sequencer_if.slave  bus_io
);

  localparam int unsigned CntW = $clog2(DIV_LATENCY + 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StSendB,
    StWait,
    StCapR,
    StZero,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             rv_q, rv_d;
  logic             dz_q, dz_d;

  // Next-state, operand latching, result capture and registered bus outputs.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    dz_d    = dz_q;
    start_d = 1'b0;
    din_d   = '0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.in_valid) begin
          a_d     = bus_io.dividend;
          b_d     = bus_io.divisor;
          state_d = (bus_io.divisor == '0) ? StZero : StStart;
        end
      end
      StStart: state_d = StSendB;
      StSendB: begin
        // Counter tracks cycles since the start cycle; WAIT begins at cycle 2.
        cnt_d   = CntW'(2);
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == CntW'(DIV_LATENCY)) begin
          quo_d   = bus_io.div_out_bus;
          cnt_d   = '0;
          state_d = StCapR;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StCapR: begin
        rem_d   = bus_io.div_out_bus;
        rv_d    = 1'b1;
        dz_d    = 1'b0;
        state_d = StDone;
      end
      StZero: begin
        quo_d   = '1;
        rem_d   = a_q;
        rv_d    = 1'b1;
        dz_d    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (bus_io.res_ready) begin
          rv_d    = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // start and the input bus are registered, so they follow the state being entered.
    start_d = (state_d == StStart);
    if (state_d == StStart) begin
      din_d = a_d;
    end else if (state_d == StSendB) begin
      din_d = b_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      din_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      rv_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      rv_q    <= rv_d;
      dz_q    <= dz_d;
    end
  end

  assign bus_io.in_ready    = (state_q == StIdle);
  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.start       = start_q;
  assign bus_io.div_in_bus  = din_q;
  assign bus_io.res_valid   = rv_q;
  assign bus_io.quotient    = quo_q;
  assign bus_io.remainder   = rem_q;
  assign bus_io.div_by_zero = dz_q;

endmodule

// File: tb/tb_div_bus_sequencer.sv
// Bench for div_bus_sequencer: behavioural divider on the bus, host-level reference
// results computed with plain arithmetic, directed cases followed by random operations.
module tb_div_bus_sequencer;

  localparam int unsigned DL = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  div_bus_sequencer_if #(.WIDTH(6)) bus_if ();

  div_bus_sequencer #(
    .WIDTH       (6),
    .DIV_LATENCY (DL)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Behavioural divider: samples A at the start cycle, B the cycle after, then shows the
  // quotient in cycle DL and the remainder in cycle DL+1; junk on the bus otherwise.
  int         div_k = -1;
  logic [5:0] div_a, div_b;
  always @(posedge clk) begin
    if (bus_if.start) begin
      div_a = bus_if.div_in_bus;
      div_k = 1;
    end else if (div_k >= 1) begin
      if (div_k == 1) div_b = bus_if.div_in_bus;
      div_k++;
      if (div_k > int'(DL) + 1) div_k = -1;
    end
    #1;
    if (div_k == int'(DL)) bus_if.div_out_bus = (div_b == 0) ? 6'h3f : div_a / div_b;
    else if (div_k == int'(DL) + 1) bus_if.div_out_bus = (div_b == 0) ? div_a : div_a % div_b;
    else bus_if.div_out_bus = 6'($urandom);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One host transaction, entered and left at a negedge. keep leaves in_valid high with
  // the next pair (nd/nv) after accept; noise pokes other operands during WAIT.
  task automatic run_op(input logic [5:0] dd, input logic [5:0] dv, input int hold,
                        input bit noise, input bit keep, input logic [5:0] nd,
                        input logic [5:0] nv);
    int         n;
    int         starts;
    bit         got;
    logic [5:0] eq, er;
    logic       ez;
    int         lat;
    if (dv == 0) begin
      eq = 6'h3f; er = dd; ez = 1'b1; lat = 2;
    end else begin
      eq = dd / dv; er = dd % dv; ez = 1'b0; lat = int'(DL) + 3;
    end
    bus_if.dividend = dd;
    bus_if.divisor  = dv;
    bus_if.in_valid = 1'b1;
    check_eq("in_ready_idle", bus_if.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    if (keep) begin
      bus_if.dividend = nd;
      bus_if.divisor  = nv;
    end else begin
      bus_if.in_valid = 1'b0;
    end
    n = 1; starts = 0; got = 0;
    while (!got && n <= 40) begin
      if (bus_if.start) begin
        starts++;
        check_eq("start_cycle", n, 1);
      end
      if (dv != 0 && n == 1) check_eq("bus_a", bus_if.div_in_bus, dd);
      if (dv != 0 && n == 2) check_eq("bus_b", bus_if.div_in_bus, dv);
      if (n == 3 || (dv == 0 && n == 1)) check_eq("bus_idle", bus_if.div_in_bus, 0);
      if (noise && dv != 0) begin
        if (n == 5) begin
          bus_if.in_valid = 1'b1;
          bus_if.dividend = 6'($urandom);
          bus_if.divisor  = 6'($urandom);
        end
        if (n == 7) bus_if.in_valid = 1'b0;
      end
      if (bus_if.res_valid) got = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check_eq("latency", n, lat);
    check_eq("start_count", starts, (dv != 0) ? 1 : 0);
    check_eq("quotient", bus_if.quotient, eq);
    check_eq("remainder", bus_if.remainder, er);
    check_eq("div_by_zero", bus_if.div_by_zero, ez);
    check_eq("busy_done", bus_if.busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", bus_if.res_valid, 1);
      check_eq("hold_q", bus_if.quotient, eq);
      check_eq("hold_r", bus_if.remainder, er);
      check_eq("hold_in_ready", bus_if.in_ready, 0);
    end
    bus_if.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.res_ready = 1'b0;
    check_eq("valid_drop", bus_if.res_valid, 0);
    check_eq("in_ready_after", bus_if.in_ready, 1);
    check_eq("busy_after", bus_if.busy, 0);
    check_eq("idle_q_kept", bus_if.quotient, eq);
    check_eq("no_early_start", bus_if.start, 0);
  endtask

  initial begin
    logic [5:0] rd, rv;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.res_ready = 1'b0;
    bus_if.dividend  = '0;
    bus_if.divisor   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_start", bus_if.start, 0);
    check_eq("rst_valid", bus_if.res_valid, 0);
    check_eq("rst_dz", bus_if.div_by_zero, 0);
    check_eq("rst_bus", bus_if.div_in_bus, 0);
    check_eq("rst_q", bus_if.quotient, 0);
    check_eq("rst_r", bus_if.remainder, 0);
    check_eq("rst_in_ready", bus_if.in_ready, 1);
    check_eq("rst_busy", bus_if.busy, 0);

    run_op(6'd45, 6'd6, 0, 0, 0, 6'd0, 6'd0);
    run_op(6'd37, 6'd0, 0, 0, 0, 6'd0, 6'd0);
    run_op(6'd63, 6'd1, 5, 0, 0, 6'd0, 6'd0);
    run_op(6'd20, 6'd7, 0, 0, 1, 6'd5, 6'd9);
    run_op(6'd5, 6'd9, 0, 0, 0, 6'd0, 6'd0);

    // Reset during WAIT of 50/4.
    bus_if.dividend = 6'd50;
    bus_if.divisor  = 6'd4;
    bus_if.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("mid_rst_start", bus_if.start, 0);
    check_eq("mid_rst_valid", bus_if.res_valid, 0);
    check_eq("mid_rst_q", bus_if.quotient, 0);
    check_eq("mid_rst_r", bus_if.remainder, 0);
    check_eq("mid_rst_bus", bus_if.div_in_bus, 0);
    check_eq("mid_rst_in_ready", bus_if.in_ready, 1);
    check_eq("mid_rst_busy", bus_if.busy, 0);
    run_op(6'd50, 6'd4, 0, 0, 0, 6'd0, 6'd0);

    run_op(6'd33, 6'd5, 1, 1, 0, 6'd0, 6'd0);

    for (int k = 0; k < 24; k++) begin
      rd = 6'($urandom);
      rv = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      run_op(rd, rv, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 0, 6'd0, 6'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
